prog_loader: RTL

- Boot-time program loader that sits directly upstream of the CPU.
- Receives a byte stream (header, then instruction words) over a valid/ready interface and writes the words into instruction memory from address 0.
- Holds the CPU stalled via cpu_run=0 until the whole image is written, then releases it.
- Replaces bench-driven preloading of instruction memory and supports reload on request.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 44 ++++
 rtl/prog_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and
// stream framing constants.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CKSUM,
    RUN,
    ERR
  } state_e;

  localparam int HDR_W      = 16;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes big-endian into 32-bit instruction words and
// flags the byte that completes each word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], byte_in};
    end
  end

  // The completing byte is combined live so the word is ready on its own edge.
  assign word_done = accept && !clr && (cnt_q == 2'(WORD_BYTES - 1));
  assign word      = {sr_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: writes a streamed image into instruction memory and
// holds the CPU until done. Optional trailer checksum via PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [HDR_W:0] MAX_WORDS = (HDR_W + 1)'(2 ** ADDR_W);

`ifdef PROG_LOADER_CKSUM_EN
  localparam state_e END_ST = CKSUM;
`else
  localparam state_e END_ST = RUN;
`endif

  state_e              state_q, state_d;
  logic [HDR_W-1:0]    n_q, n_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                load_err_q, load_err_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                acc, restart, word_done;
  logic [31:0]         word;
  logic [HDR_W:0]      hdr_n, next_count;

  assign in_ready = rst && (state_q == HDR0 || state_q == HDR1 ||
                            state_q == DATA || state_q == CKSUM);
  assign acc      = in_valid && in_ready;
  assign hdr_n    = {1'b0, n_q[HDR_W-1:8], in_data};
  assign next_count = {{(HDR_W - ADDR_W){1'b0}}, words_loaded_q} + (HDR_W + 1)'(1);

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (restart)
      cks_d = '0;
    else if (acc && state_q == DATA)
      cks_d = cks_q ^ in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cks_q <= '0;
    else      cks_q <= cks_d;
  end
`endif

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (restart),
    .accept    (acc && state_q == DATA),
    .byte_in   (in_data),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;
    restart        = 1'b0;
    case (state_q)
      HDR0: if (acc) begin
        n_d     = {in_data, 8'h00};
        state_d = HDR1;
      end
      HDR1: if (acc) begin
        n_d = hdr_n[HDR_W-1:0];
        if (hdr_n > MAX_WORDS)    state_d = ERR;
        else if (hdr_n == '0)     state_d = END_ST;
        else                      state_d = DATA;
      end
      DATA: if (word_done) begin
        imem_we_d      = 1'b1;
        imem_addr_d    = words_loaded_q[ADDR_W-1:0];
        imem_wdata_d   = word;
        words_loaded_d = next_count[ADDR_W:0];
        if (next_count == {1'b0, n_q}) state_d = END_ST;
      end
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: if (acc) state_d = (in_data == cks_q) ? RUN : ERR;
`endif
      RUN, ERR: if (load_req) begin
        state_d        = HDR0;
        words_loaded_d = '0;
        restart        = 1'b1;
      end
      default: state_d = ERR;
    endcase
    // cpu_run lags RUN entry by one edge so the final write lands first.
    cpu_run_d  = (state_q == RUN) && (state_d == RUN);
    load_err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= HDR0;
      n_q            <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_run_q      <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_run_q      <= cpu_run_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule
